// File: rtl/wallace_multiplier_16bit_by_16bit.sv
// wallace_multiplier_16bit_by_16bit: unsigned 16x16 -> 32 multiplier, Wallace-tree reduction, registered product
// Ports:
//    clk     - sole clock, rising edge
//    rst     - synchronous active-high reset, clears every register
//    a       - 16-bit unsigned multiplicand
//    b       - 16-bit unsigned multiplier
//    product - 32-bit registered a*b
// Build option WALLACE_INPUT_REG_EN: registers a and b ahead of the tree (latency 2 instead of 1).
module wallace_multiplier_16bit_by_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] product
);
   logic [15:0] w_a, w_b;
   logic [31:0] w_row0, w_row1, w_sum;
   logic [31:0] r_product;
`ifdef WALLACE_INPUT_REG_EN
   logic [15:0] r_a, r_b;
   always_ff @(posedge clk)
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= a;
         r_b <= b;
      end
   assign w_a = r_a;
   assign w_b = r_b;
`else
   assign w_a = a;
   assign w_b = b;
`endif
   // Each column is a bit bag: cur[c] holds h[c] bits of weight 2^c packed from bit 0.
   // A stage rebuilds every column from groups of three (full adder), a leftover pair
   // (half adder) or a lone bit (pass-through); stages stop once no column exceeds two bits.
   always_comb begin
      logic [31:0] cur [32];
      logic [31:0] nxt [32];
      logic [4:0]  h   [32];
      logic [4:0]  nh  [32];
      logic [4:0]  k;
      logic        done, x0, x1, x2;
      for (int c = 0; c < 32; c++) begin
         cur[c] = '0;
         nxt[c] = '0;
         h[c]   = '0;
         nh[c]  = '0;
      end
      k    = '0;
      done = 1'b0;
      x0   = 1'b0;
      x1   = 1'b0;
      x2   = 1'b0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin
            cur[i+j][h[i+j]] = w_a[j] & w_b[i];
            h[i+j] = h[i+j] + 5'd1;
         end
      for (int s = 0; s < 8; s++) begin
         done = 1'b1;
         for (int c = 0; c < 32; c++)
            if (h[c] > 5'd2) done = 1'b0;
         if (!done) begin
            for (int c = 0; c < 32; c++) begin
               nxt[c] = '0;
               nh[c]  = '0;
            end
            for (int c = 0; c < 32; c++)
               for (int g = 0; g < 6; g++) begin
                  k  = 5'(3 * g);
                  x0 = cur[c][k];
                  x1 = cur[c][k+5'd1];
                  x2 = cur[c][k+5'd2];
                  if (k + 5'd2 < h[c]) begin
                     nxt[c][nh[c]] = x0 ^ x1 ^ x2;
                     nh[c] = nh[c] + 5'd1;
                     // carries out of column 31 are zero for any 16x16 product
                     if (c < 31) begin
                        nxt[c+1][nh[c+1]] = (x0 & x1) | (x2 & (x0 ^ x1));
                        nh[c+1] = nh[c+1] + 5'd1;
                     end
                  end else if (k + 5'd1 < h[c]) begin
                     nxt[c][nh[c]] = x0 ^ x1;
                     nh[c] = nh[c] + 5'd1;
                     if (c < 31) begin
                        nxt[c+1][nh[c+1]] = x0 & x1;
                        nh[c+1] = nh[c+1] + 5'd1;
                     end
                  end else if (k < h[c]) begin
                     nxt[c][nh[c]] = x0;
                     nh[c] = nh[c] + 5'd1;
                  end
               end
            for (int c = 0; c < 32; c++) begin
               cur[c] = nxt[c];
               h[c]   = nh[c];
            end
         end
      end
      for (int c = 0; c < 32; c++) begin
         w_row0[c] = cur[c][0];
         w_row1[c] = cur[c][1];
      end
   end
   // final carry-propagate adder; carry out of bit 31 is dropped
   assign w_sum = w_row0 + w_row1;
   always_ff @(posedge clk)
      if (rst) r_product <= '0;
      else     r_product <= w_sum;
   assign product = r_product;
endmodule

// File: tb/tb_wallace_multiplier_16bit_by_16bit.sv
// tb_wallace_multiplier_16bit_by_16bit: directed and random checks of the 16x16 multiplier against an arithmetic model
module tb_wallace_multiplier_16bit_by_16bit;
`ifdef WALLACE_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [31:0] product;
   logic [31:0] pipe [LAT];
   int          n_chk = 0;
   int          n_fail = 0;

   wallace_multiplier_16bit_by_16bit dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] exp);
      n_chk++;
      assert (product === exp) else begin
         n_fail++;
         $error("FAIL %s: product=%h expected=%h", tag, product, exp);
      end
   endtask

   // one clock: drive, clock, advance the model, check product against the model
   task automatic step(input logic [15:0] sa, input logic [15:0] sb, input logic sr, input string tag);
      a   = sa;
      b   = sb;
      rst = sr;
      @(posedge clk);
      if (sr)
         for (int k = 0; k < LAT; k++) pipe[k] = '0;
      else begin
         for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = 32'(sa) * 32'(sb);
      end
      #1;
      check(tag, pipe[LAT-1]);
   endtask

   // hold a pair for the full latency, then compare with a hand-derived constant
   task automatic hold(input logic [15:0] sa, input logic [15:0] sb, input logic [31:0] exp, input string tag);
      for (int k = 0; k < LAT; k++) step(sa, sb, 1'b0, tag);
      check({tag, "_const"}, exp);
   endtask

   initial begin
      for (int k = 0; k < LAT; k++) pipe[k] = '0;
      step(16'h1234, 16'h5678, 1'b1, "reset0");
      step(16'h1234, 16'h5678, 1'b1, "reset1");
      check("reset_const", 32'h0000_0000);
      hold(16'd5, 16'd3, 32'h0000_000F, "5x3");
      hold(16'd91, 16'd44, 32'h0000_0FA4, "91x44");
      hold(16'hCDCD, 16'hBABA, 32'h961C_78F2, "cdcd_baba");
      hold(16'hFFFF, 16'hFBFB, 32'hFBFA_0405, "ffff_fbfb");
      hold(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffff_ffff");
      hold(16'h0000, 16'hA5A5, 32'h0000_0000, "a_zero");
      hold(16'h5A5A, 16'h0000, 32'h0000_0000, "b_zero");
      hold(16'h8000, 16'h8000, 32'h4000_0000, "msb_msb");
      hold(16'h0001, 16'hFFFF, 32'h0000_FFFF, "one_max");
      for (int n = 0; n < 300; n++)
         step(16'($urandom), 16'($urandom), 1'b0, "stream");
      for (int n = 0; n < 40; n++)
         step(16'($urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom)),
              16'($urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom)), 1'b0, "stream_edge");
      step(16'($urandom), 16'($urandom), 1'b1, "midrst");
      check("midrst_const", 32'h0000_0000);
      step(16'd7, 16'd9, 1'b0, "post_rst0");
      step(16'($urandom), 16'($urandom), 1'b0, "post_rst1");
      for (int n = 0; n < 100; n++)
         step(16'($urandom), 16'($urandom), ($urandom_range(0, 15) == 0), "stream_rst");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
